// File: rtl/sum_3_inv_pkg.sv
// Shared widths, state encoding and saturation limits for the sum_3 / sum_3_inv filter pair.
package sum_3_inv_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int SUM_TAPS   = 3;
   localparam int SUM_GROWTH = $clog2(SUM_TAPS);  // bits a SUM_TAPS-term sum grows by

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } state_t;

   function automatic int sat_hi(int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_lo(int w);
      return -(1 << (w - 1));
   endfunction
endpackage

// File: rtl/sum_3_inv.sv
// Inverse 3-tap moving sum: recovers x[n] from y[n]=x[n]+x[n-1]+x[n-2], one register stage.
// Input stalls while a result is held; an out-of-range result is saturated and latches err.
module sum_3_inv
   import sum_3_inv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int SUM_W  = DATA_W + SUM_GROWTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [SUM_W-1:0]  in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out,
   output logic                     err
);
   localparam int R_W = SUM_W + 2;
   localparam logic signed [DATA_W-1:0] SAT_HI = DATA_W'(sat_hi(DATA_W));
   localparam logic signed [DATA_W-1:0] SAT_LO = DATA_W'(sat_lo(DATA_W));

   state_t                    state, state_nxt;
   logic signed [SUM_W-1:0]   y_prev, y_prev_nxt;
   logic signed [DATA_W-1:0]  x1, x2, x3;
   logic signed [DATA_W-1:0]  x1_nxt, x2_nxt, x3_nxt, out_nxt;
   logic                      out_valid_nxt, err_nxt;
   logic signed [R_W-1:0]     r;
   logic                      in_range, accept, xfer;

   assign in_ready = (state == FAULT) | ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;
   assign xfer     = out_valid & out_ready;

   // x[n] = y[n] - y[n-1] + x[n-3]; sign-extended so nothing wraps
   assign r        = R_W'(in) - R_W'(y_prev) + R_W'(x3);
   assign in_range = (r[R_W-1:DATA_W-1] == '0) || (r[R_W-1:DATA_W-1] == '1);

   always_comb begin
      state_nxt     = state;
      y_prev_nxt    = y_prev;
      x1_nxt        = x1;
      x2_nxt        = x2;
      x3_nxt        = x3;
      out_nxt       = out;
      out_valid_nxt = out_valid;
      err_nxt       = err;

      if (xfer) begin
         out_valid_nxt = 1'b0;
      end

      // in FAULT accepted samples are simply dropped
      if (accept && state == RUN) begin
         out_valid_nxt = 1'b1;
         if (in_range) begin
            out_nxt    = r[DATA_W-1:0];
            x3_nxt     = x2;
            x2_nxt     = x1;
            x1_nxt     = r[DATA_W-1:0];
            y_prev_nxt = in;
         end else begin
            out_nxt   = r[R_W-1] ? SAT_LO : SAT_HI;
            err_nxt   = 1'b1;
            state_nxt = FAULT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         y_prev    <= '0;
         x1        <= '0;
         x2        <= '0;
         x3        <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         y_prev    <= y_prev_nxt;
         x1        <= x1_nxt;
         x2        <= x2_nxt;
         x3        <= x3_nxt;
         out       <= out_nxt;
         out_valid <= out_valid_nxt;
         err       <= err_nxt;
      end
   end
endmodule

// File: tb/tb_sum_3_inv.sv
// Self-checking bench for sum_3_inv: directed vectors plus a randomized sum_3 loopback.
module tb_sum_3_inv;
   import sum_3_inv_pkg::*;

   localparam int DW = DEF_DATA_W;
   localparam int SW = DW + SUM_GROWTH;
   localparam int N  = 1000;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [SW-1:0] in_sum;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out_x;
   logic                 err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sum_3_inv #(.DATA_W(DW), .SUM_W(SW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in       (in_sum),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (out_x),
      .err      (err)
   );

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // present one sample for exactly one edge; caller has verified in_ready
   task automatic offer(input int y);
      in_valid = 1'b1;
      in_sum   = SW'(y);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || out_x !== '0 || err !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: out_valid=%b out=%0d err=%b in_ready=%b, want 0 0 0 1",
                  out_valid, out_x, err, in_ready);
      end
   endtask

   task automatic test_basic();
      int ys[6];
      int xs[6];
      ys = '{2, 3, 2, 0, -1, 0};
      xs = '{2, 1, -1, 0, 0, 0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         offer(ys[i]);
         checks++;
         if (out_valid !== 1'b1 || out_x !== DW'(xs[i]) || err !== 1'b0) begin
            errors++;
            $display("FAIL basic[%0d]: valid=%b out=%0d err=%b, want 1 %0d 0",
                     i, out_valid, out_x, err, xs[i]);
         end
      end
   endtask

   task automatic test_full_scale();
      int ys[8];
      int xs[8];
      ys = '{127, 254, 381, 381, -128, -256, -384, -384};
      xs = '{127, 127, 127, 127, -128, -128, -128, -128};
      for (int i = 0; i < 8; i++) begin
         if (i % 4 == 0) do_reset();
         offer(ys[i]);
         checks++;
         if (out_valid !== 1'b1 || out_x !== DW'(xs[i]) || err !== 1'b0) begin
            errors++;
            $display("FAIL full_scale[%0d]: valid=%b out=%0d err=%b, want 1 %0d 0",
                     i, out_valid, out_x, err, xs[i]);
         end
      end
   endtask

   task automatic test_fault();
      do_reset();
      offer(200);
      checks++;
      if (out_valid !== 1'b1 || out_x !== 8'sd127 || err !== 1'b1) begin
         errors++;
         $display("FAIL fault_sat: valid=%b out=%0d err=%b, want 1 127 1", out_valid, out_x, err);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fault_ready[%0d]: in_ready=%b, want 1", i, in_ready);
         end
         offer(i + 1);
         checks++;
         if (out_valid !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL fault_drop[%0d]: valid=%b err=%b, want 0 1", i, out_valid, err);
         end
      end
      do_reset();
      offer(5);
      checks++;
      if (out_valid !== 1'b1 || out_x !== 8'sd5 || err !== 1'b0) begin
         errors++;
         $display("FAIL fault_recover: valid=%b out=%0d err=%b, want 1 5 0", out_valid, out_x, err);
      end
      do_reset();
      offer(-200);
      checks++;
      if (out_valid !== 1'b1 || out_x !== -8'sd128 || err !== 1'b1) begin
         errors++;
         $display("FAIL fault_neg: valid=%b out=%0d err=%b, want 1 -128 1", out_valid, out_x, err);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      offer(2);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sum    = SW'(3);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_x !== 8'sd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall[%0d]: valid=%b out=%0d in_ready=%b, want 1 2 0",
                     i, out_valid, out_x, in_ready);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_x !== 8'sd1) begin
         errors++;
         $display("FAIL release: valid=%b out=%0d, want 1 1", out_valid, out_x);
      end
      offer(2);
      checks++;
      if (out_x !== -8'sd1) begin
         errors++;
         $display("FAIL after_release: out=%0d, want -1", out_x);
      end
   endtask

   task automatic test_rst_mid();
      do_reset();
      offer(2);
      offer(3);
      offer(2);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_sum   = SW'(50);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_x !== '0 || err !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: valid=%b out=%0d err=%b, want 0 0 0", out_valid, out_x, err);
      end
      offer(4);
      checks++;
      if (out_valid !== 1'b1 || out_x !== 8'sd4) begin
         errors++;
         $display("FAIL rst_history: valid=%b out=%0d, want 1 4", out_valid, out_x);
      end
   endtask

   // sum_3 reference: y[n] is the plain sum of the last three x, zero before reset
   task automatic test_loopback();
      int xs[N];
      int ys[N];
      int q[$];
      int idx = 0;
      int rcv = 0;
      int cyc = 0;
      int e;
      bit acc_pend = 1'b0;
      for (int n = 0; n < N; n++) xs[n] = int'($urandom_range(0, 255)) - 128;
      for (int n = 0; n < N; n++)
         ys[n] = xs[n] + ((n >= 1) ? xs[n-1] : 0) + ((n >= 2) ? xs[n-2] : 0);
      do_reset();
      while (rcv < N && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (acc_pend) begin
            in_valid = 1'b0;
            acc_pend = 1'b0;
         end
         if (!in_valid && idx < N) in_valid = ($urandom_range(0, 3) != 0);
         if (in_valid) in_sum = SW'(ys[idx]);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL loopback_extra: out=%0d with nothing outstanding", out_x);
            end else begin
               e = q.pop_front();
               if (out_x !== DW'(e)) begin
                  errors++;
                  $display("FAIL loopback[%0d]: out=%0d, want %0d", rcv, out_x, e);
               end
               rcv++;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(xs[idx]);
            idx++;
            acc_pend = 1'b1;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (rcv != N || err !== 1'b0) begin
         errors++;
         $display("FAIL loopback_done: received=%0d err=%b, want %0d 0", rcv, err, N);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
      test_reset();
      test_basic();
      test_full_scale();
      test_fault();
      test_backpressure();
      test_rst_mid();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
